// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - button pin and strobe bundle between the board pins and the conditioner
interface btn_conditioner_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] BTN_RAW;
    logic [N_BTN-1:0] BTN_LEVEL;
    logic [N_BTN-1:0] BTN_PRESS;
    logic [N_BTN-1:0] BTN_RELEASE;

    // pin side: drives the raw pins, consumes the conditioned strobes
    modport master (
        output BTN_RAW,
        input  BTN_LEVEL,
        input  BTN_PRESS,
        input  BTN_RELEASE
    );

    // conditioner side
    modport slave (
        input  BTN_RAW,
        output BTN_LEVEL,
        output BTN_PRESS,
        output BTN_RELEASE
    );
endinterface

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - per-channel synchroniser, debouncer and press/release strobe generator; auto-repeat under BTN_AUTOREPEAT_EN
module btn_conditioner #(
    parameter int               N_BTN          = 3,
    parameter int               DEB_CYCLES     = 1000000,
    parameter int               BTN_ACTIVE_LOW = 0,
    parameter int               HOLD_CYCLES    = 50000000,
    parameter int               REPEAT_CYCLES  = 10000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK    = 3'b011
) (
    input  logic               CLK,
    input  logic               RESET,
    btn_conditioner_if.slave   btn
);

    localparam int MAX_HR  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int MAX_ALL = (DEB_CYCLES > MAX_HR) ? DEB_CYCLES : MAX_HR;
    localparam int CNT_W   = $clog2(MAX_ALL);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    // After each repeat strobe the counter restarts REPEAT_CYCLES below the
    // firing point, so one compare serves both the first hold and the period.
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_RELOAD =
        CNT_W'((HOLD_CYCLES >= REPEAT_CYCLES) ? (HOLD_CYCLES - REPEAT_CYCLES) : 0);
`endif

    logic [N_BTN-1:0] raw_in;
    logic [N_BTN-1:0] sync_a;
    logic [N_BTN-1:0] sync_b;

    // normalise polarity so 1 always means pressed from here on
    assign raw_in = (BTN_ACTIVE_LOW != 0) ? ~btn.BTN_RAW : btn.BTN_RAW;

    // two-flop synchroniser; reset value reads as released
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw_in;
            sync_b <= sync_a;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        typedef enum logic [1:0] {
            IDLE         = 2'd0,
            PRESS_WAIT   = 2'd1,
            HELD         = 2'd2,
            RELEASE_WAIT = 2'd3
        } state_t;

        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             level_q;
        logic             press_q;
        logic             rel_q;
        logic             sync_bit;

        assign sync_bit = sync_b[i];

`ifdef BTN_AUTOREPEAT_EN
        logic [CNT_W-1:0] rpt_cnt;

        // debounce FSM with held-time counter; rpt_cnt only moves in HELD, so
        // a release bounce freezes it and a bounce back resumes it
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                state   <= IDLE;
                cnt     <= '0;
                rpt_cnt <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                case (state)
                    IDLE: begin
                        if (sync_bit) begin
                            state <= PRESS_WAIT;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync_bit) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == DEB_LAST) begin
                            state   <= HELD;
                            cnt     <= '0;
                            press_q <= 1'b1;
                            level_q <= 1'b1;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!sync_bit) begin
                            state <= RELEASE_WAIT;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt <= '0;
                            if (REPEAT_MASK[i]) begin
                                if (rpt_cnt == HOLD_LAST) begin
                                    press_q <= 1'b1;
                                    rpt_cnt <= RPT_RELOAD;
                                end else if (rpt_cnt != CNT_MAX) begin
                                    rpt_cnt <= rpt_cnt + CNT_ONE;
                                end
                            end
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync_bit) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == DEB_LAST) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            rpt_cnt <= '0;
                            rel_q   <= 1'b1;
                            level_q <= 1'b0;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
`else
        // debounce FSM: a level is accepted only after DEB_CYCLES identical samples
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                state   <= IDLE;
                cnt     <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                case (state)
                    IDLE: begin
                        if (sync_bit) begin
                            state <= PRESS_WAIT;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync_bit) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == DEB_LAST) begin
                            state   <= HELD;
                            cnt     <= '0;
                            press_q <= 1'b1;
                            level_q <= 1'b1;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!sync_bit) begin
                            state <= RELEASE_WAIT;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync_bit) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == DEB_LAST) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            rel_q   <= 1'b1;
                            level_q <= 1'b0;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
`endif

        assign btn.BTN_LEVEL[i]   = level_q;
        assign btn.BTN_PRESS[i]   = press_q;
        assign btn.BTN_RELEASE[i] = rel_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed and randomized bench for btn_conditioner against a run-length reference model
module tb_btn_conditioner;

    localparam int         DEB   = 4;
    localparam int         HOLD  = 10;
    localparam int         REP   = 3;
    localparam logic [2:0] RMASK = 3'b011;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    localparam int HOLD_EXP = AR ? 8 : 1;

    logic clk = 1'b0;
    logic rst_n;

    btn_conditioner_if #(.N_BTN(3)) bif ();

    btn_conditioner #(
        .N_BTN          (3),
        .DEB_CYCLES     (DEB),
        .BTN_ACTIVE_LOW (0),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP),
        .REPEAT_MASK    (RMASK)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .btn   (bif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state: accepted level, run of disagreeing samples, held ticks
    logic [2:0] m_level, m_press, m_release, m_prev;
    logic [2:0] dq[$];
    int         m_run[3];
    int         m_ticks[3];
    int         pcnt[3];
    int         rcnt[3];

    task automatic model_reset();
        m_level = '0; m_press = '0; m_release = '0; m_prev = '0;
        dq = {3'b000, 3'b000};
        for (int i = 0; i < 3; i++) begin
            m_run[i] = 0;
            m_ticks[i] = 0;
        end
    endtask

    // the debouncer sees the pin as it was two edges earlier
    task automatic model_edge(input logic [2:0] raw);
        logic [2:0] samp;
        bit held;
        samp = dq.pop_front();
        dq.push_back(raw);
        m_press = '0;
        m_release = '0;
        for (int i = 0; i < 3; i++) begin
            held = m_level[i] && m_prev[i] && samp[i];
            if (samp[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_level[i] = samp[i];
                    m_run[i] = 0;
                    if (samp[i]) m_press[i] = 1'b1;
                    else begin
                        m_release[i] = 1'b1;
                        m_ticks[i] = 0;
                    end
                end
            end else begin
                m_run[i] = 0;
            end
            if (AR && held && RMASK[i]) begin
                m_ticks[i]++;
                if (m_ticks[i] >= HOLD && ((m_ticks[i] - HOLD) % REP) == 0) m_press[i] = 1'b1;
            end
        end
        m_prev = samp;
    endtask

    task automatic check_outputs();
        total++;
        assert (bif.BTN_LEVEL === m_level) else begin
            bad++; $error("FAIL level: got %b want %b at %0t", bif.BTN_LEVEL, m_level, $time);
        end
        total++;
        assert (bif.BTN_PRESS === m_press) else begin
            bad++; $error("FAIL press: got %b want %b at %0t", bif.BTN_PRESS, m_press, $time);
        end
        total++;
        assert (bif.BTN_RELEASE === m_release) else begin
            bad++; $error("FAIL release: got %b want %b at %0t", bif.BTN_RELEASE, m_release, $time);
        end
    endtask

    task automatic expect_eq(input string tag, input int got, input int want);
        total++;
        assert (got === want) else begin
            bad++; $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            pcnt[i] = 0;
            rcnt[i] = 0;
        end
    endtask

    task automatic step(input logic [2:0] raw);
        bif.BTN_RAW = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        check_outputs();
        for (int i = 0; i < 3; i++) begin
            if (bif.BTN_PRESS[i] === 1'b1) pcnt[i]++;
            if (bif.BTN_RELEASE[i] === 1'b1) rcnt[i]++;
        end
    endtask

    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        expect_eq("reset_level_clear", int'(bif.BTN_LEVEL), 0);
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        int runleft[3];
        logic [2:0] r;

        // reset with all buttons held
        rst_n = 1'b0;
        bif.BTN_RAW = 3'b111;
        model_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        expect_eq("reset_outputs", int'({bif.BTN_LEVEL, bif.BTN_PRESS, bif.BTN_RELEASE}), 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(3'b111);
            if (k == 5) expect_eq("held_through_reset_early", int'(bif.BTN_PRESS), 0);
            if (k == 6) expect_eq("held_through_reset_press", int'(bif.BTN_PRESS), 7);
            if (k == 7) expect_eq("held_through_reset_level", int'(bif.BTN_LEVEL), 7);
        end
        repeat (8) step(3'b000);
        expect_eq("all_released", int'(bif.BTN_LEVEL), 0);

        // press bounce rejection, then a clean 4-cycle press
        clear_counts();
        step(3'b001); step(3'b000); step(3'b001); step(3'b000);
        repeat (6) step(3'b000);
        expect_eq("bounce_no_press", pcnt[0], 0);
        expect_eq("bounce_level", int'(bif.BTN_LEVEL[0]), 0);
        clear_counts();
        for (int k = 1; k <= 6; k++) begin
            step((k <= 4) ? 3'b001 : 3'b000);
            if (k == 6) expect_eq("clean_press_e5", int'(bif.BTN_PRESS[0]), 1);
        end
        repeat (8) step(3'b000);
        expect_eq("clean_press_count", pcnt[0], 1);
        expect_eq("short_press_release", rcnt[0], 1);

        // release bounce on channel 1
        repeat (7) step(3'b010);
        clear_counts();
        repeat (2) step(3'b000);
        repeat (6) step(3'b010);
        expect_eq("release_bounce_none", rcnt[1], 0);
        expect_eq("release_bounce_level", int'(bif.BTN_LEVEL[1]), 1);
        repeat (8) step(3'b000);
        expect_eq("clean_release_count", rcnt[1], 1);
        expect_eq("clean_release_level", int'(bif.BTN_LEVEL[1]), 0);

        // asynchronous reset mid-debounce with another channel held
        repeat (7) step(3'b001);
        repeat (4) step(3'b101);
        async_reset();
        clear_counts();
        for (int k = 1; k <= 6; k++) begin
            step(3'b101);
            if (k == 5) expect_eq("post_reset_no_early", pcnt[0] + pcnt[2], 0);
            if (k == 6) expect_eq("post_reset_press", int'(bif.BTN_PRESS), 5);
        end
        repeat (8) step(3'b000);

        // long hold: repeat train on masked channel 0, single press on channel 2
        clear_counts();
        for (int k = 1; k <= 36; k++) step(3'b101);
        expect_eq("hold_ch0_presses", pcnt[0], HOLD_EXP);
        expect_eq("hold_ch2_presses", pcnt[2], 1);
        expect_eq("hold_level", int'(bif.BTN_LEVEL), 5);
        repeat (10) step(3'b000);

        // simultaneous presses on two channels
        clear_counts();
        for (int k = 1; k <= 36; k++) begin
            step(3'b011);
            if (k == 6) expect_eq("simultaneous_press", int'(bif.BTN_PRESS), 3);
        end
        expect_eq("simul_ch0_presses", pcnt[0], HOLD_EXP);
        expect_eq("simul_ch1_presses", pcnt[1], HOLD_EXP);
        repeat (10) step(3'b000);
        expect_eq("simul_releases", rcnt[0] + rcnt[1], 2);

        // randomized run lengths straddling the debounce window
        r = 3'b000;
        for (int i = 0; i < 3; i++) runleft[i] = 1;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                runleft[i]--;
                if (runleft[i] <= 0) begin
                    r[i] = ~r[i];
                    runleft[i] = (($urandom_range(0, 3) == 0) ? $urandom_range(15, 40)
                                                               : $urandom_range(1, 7));
                end
            end
            step(r);
            if (n == 300) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
